// File: rtl/adc_self_trigger_pkg.sv
// Shared types and latencies for the BPM self-trigger block.
package adc_self_trigger_pkg;

   typedef enum logic [1:0] {
      ST_ARMED   = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_HOLDOFF = 2'd2
   } trig_state_t;

   // Input sample to magnitude register: latch 1 + multiply 4 + sum 1 + register 1.
   localparam int MAG_LATENCY      = 7;
   localparam int MUL_STAGES       = 4;
   localparam int DECISION_LATENCY = MAG_LATENCY + 1;
   localparam int TRIG_CNT_WIDTH   = 16;

   function automatic logic [TRIG_CNT_WIDTH-1:0] sat_inc(input logic [TRIG_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/adc_self_trigger_if.sv
// Sample/config/result bundle of adc_self_trigger; rearmThreshold exists only
// when ADC_SELF_TRIGGER_HYST_EN is defined.
interface adc_self_trigger_if
   import adc_self_trigger_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int ADC_WIDTH    = 14,
   parameter int DATA_WIDTH   = 16,
   parameter int COUNT_WIDTH  = 8
) ();

   logic                               adcValidIn;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0] adcIIn;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0] adcQIn;
   logic [NUM_CHANNELS*2*ADC_WIDTH-1:0] threshold;
`ifdef ADC_SELF_TRIGGER_HYST_EN
   logic [NUM_CHANNELS*2*ADC_WIDTH-1:0] rearmThreshold;
`endif
   logic [NUM_CHANNELS-1:0]            channelEnable;
   logic [COUNT_WIDTH-1:0]             postCount;
   logic [COUNT_WIDTH-1:0]             holdoff;

   logic                               adcValidOut;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0] adcIOut;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0] adcQOut;
   logic [NUM_CHANNELS-1:0]            adcChannelsAbove;
   logic                               adcExceedsThreshold;
   logic                               adcUseThisSample;
   logic                               adcTriggerStrobe;
   logic [TRIG_CNT_WIDTH-1:0]          adcTriggerCount;

   modport slave (
`ifdef ADC_SELF_TRIGGER_HYST_EN
      input  rearmThreshold,
`endif
      input  adcValidIn, adcIIn, adcQIn, threshold, channelEnable, postCount, holdoff,
      output adcValidOut, adcIOut, adcQOut, adcChannelsAbove, adcExceedsThreshold,
             adcUseThisSample, adcTriggerStrobe, adcTriggerCount
   );

   modport master (
`ifdef ADC_SELF_TRIGGER_HYST_EN
      output rearmThreshold,
`endif
      output adcValidIn, adcIIn, adcQIn, threshold, channelEnable, postCount, holdoff,
      input  adcValidOut, adcIOut, adcQOut, adcChannelsAbove, adcExceedsThreshold,
             adcUseThisSample, adcTriggerStrobe, adcTriggerCount
   );

endinterface

// File: rtl/adc_self_trigger_iq_magnitude.sv
// Pipelined exact I^2+Q^2 for one channel, valid carried alongside the data.
module iq_magnitude
   import adc_self_trigger_pkg::*;
#(
   parameter int ADC_WIDTH = 14
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_valid,
   input  logic signed [ADC_WIDTH-1:0] i_i,
   input  logic signed [ADC_WIDTH-1:0] i_q,
   output logic                        o_valid,
   output logic [2*ADC_WIDTH-1:0]      o_mag
);

   localparam int PW = 2*ADC_WIDTH;

   logic [MAG_LATENCY:1]        r_vld_pipe;
   logic signed [ADC_WIDTH-1:0] r_i, r_q;
   logic [MUL_STAGES-1:0][PW-1:0] r_isq, r_qsq;
   logic [PW-1:0]               r_sum, r_mag;
   logic signed [PW-1:0]        w_isq, w_qsq;

   // Squares of signed fields are non-negative and fit PW bits; the sum of two
   // squares peaks at 2^(PW-1), so the unsigned PW-bit add never wraps.
   assign w_isq = r_i * r_i;
   assign w_qsq = r_q * r_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_vld_pipe <= '0;
         r_i        <= '0;
         r_q        <= '0;
         r_isq      <= '0;
         r_qsq      <= '0;
         r_sum      <= '0;
         r_mag      <= '0;
      end else begin
         r_vld_pipe <= {r_vld_pipe[MAG_LATENCY-1:1], i_valid};
         r_i        <= i_i;
         r_q        <= i_q;
         r_isq      <= {r_isq[MUL_STAGES-2:0], w_isq};
         r_qsq      <= {r_qsq[MUL_STAGES-2:0], w_qsq};
         r_sum      <= r_isq[MUL_STAGES-1] + r_qsq[MUL_STAGES-1];
         r_mag      <= r_sum;
      end
   end

   assign o_valid = r_vld_pipe[MAG_LATENCY];
   assign o_mag   = r_mag;

endmodule

// File: rtl/adc_self_trigger.sv
// Self-trigger for single-pass BPM acquisition: magnitude compare, window FSM and
// data delay. Define ADC_SELF_TRIGGER_HYST_EN to add rearm hysteresis.
module adc_self_trigger
   import adc_self_trigger_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int ADC_WIDTH    = 14,
   parameter int DATA_WIDTH   = 16,
   parameter int DELAY        = 12,
   parameter int COUNT_WIDTH  = 8
) (
   input logic              adcClk,
   input logic              adcReset_n,
   adc_self_trigger_if.slave bus
);

   localparam int MW = 2*ADC_WIDTH;
   localparam int BW = NUM_CHANNELS*DATA_WIDTH;

   if (DATA_WIDTH < ADC_WIDTH) begin : g_bad_width
      $error("adc_self_trigger: DATA_WIDTH must be >= ADC_WIDTH");
   end
   if (DELAY < 8) begin : g_bad_delay
      $error("adc_self_trigger: DELAY must be >= 8");
   end

`ifdef ADC_SELF_TRIGGER_HYST_EN
   localparam bit HYST_ON = 1'b1;
`else
   localparam bit HYST_ON = 1'b0;
`endif

   logic [NUM_CHANNELS-1:0]         w_mag_vld;
   logic [NUM_CHANNELS-1:0][MW-1:0] w_mag;
   logic [NUM_CHANNELS-1:0]         w_above;
   logic [NUM_CHANNELS-1:0]         w_rearm_ok;
   logic                            w_dec_vld;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      iq_magnitude #(.ADC_WIDTH(ADC_WIDTH)) u_mag (
         .i_clk   (adcClk),
         .i_rst_n (adcReset_n),
         .i_valid (bus.adcValidIn),
         .i_i     (bus.adcIIn[c*DATA_WIDTH + DATA_WIDTH-1 -: ADC_WIDTH]),
         .i_q     (bus.adcQIn[c*DATA_WIDTH + DATA_WIDTH-1 -: ADC_WIDTH]),
         .o_valid (w_mag_vld[c]),
         .o_mag   (w_mag[c])
      );
      assign w_above[c] = bus.channelEnable[c] & (w_mag[c] > bus.threshold[c*MW +: MW]);
`ifdef ADC_SELF_TRIGGER_HYST_EN
      assign w_rearm_ok[c] = ~bus.channelEnable[c] | (w_mag[c] <= bus.rearmThreshold[c*MW +: MW]);
`else
      assign w_rearm_ok[c] = 1'b1;
`endif
   end

   // All lanes share one valid stream, so their valid pipes are identical.
   assign w_dec_vld = &w_mag_vld;

   trig_state_t               r_state;
   logic [COUNT_WIDTH-1:0]    r_cnt, r_hcnt;
   logic [TRIG_CNT_WIDTH-1:0] r_trig_cnt;
   logic                      r_strobe, r_use, r_exceeds, r_inhibit;
   logic [NUM_CHANNELS-1:0]   r_above;

   always_ff @(posedge adcClk) begin
      if (!adcReset_n) begin
         r_state    <= ST_ARMED;
         r_cnt      <= '0;
         r_hcnt     <= '0;
         r_trig_cnt <= '0;
         r_strobe   <= 1'b0;
         r_use      <= 1'b0;
         r_exceeds  <= 1'b0;
         r_above    <= '0;
         r_inhibit  <= 1'b0;
      end else begin
         r_strobe <= 1'b0;
         if (w_dec_vld) begin
            r_above   <= w_above;
            r_exceeds <= |w_above;
            case (r_state)
               ST_ARMED: begin
                  if (!r_inhibit && (|w_above)) begin
                     r_state    <= ST_ACTIVE;
                     r_use      <= 1'b1;
                     r_strobe   <= 1'b1;
                     r_trig_cnt <= sat_inc(r_trig_cnt);
                     r_cnt      <= bus.postCount;
                  end
                  // The quiet sample that clears the inhibit is itself not a trigger.
                  if (r_inhibit && (&w_rearm_ok)) r_inhibit <= 1'b0;
               end
               ST_ACTIVE: begin
                  if (|w_above) begin
                     r_cnt <= bus.postCount;
                  end else if (r_cnt != '0) begin
                     r_cnt <= r_cnt - 1'b1;
                  end else if (bus.holdoff == '0) begin
                     r_state   <= ST_ARMED;
                     r_use     <= 1'b0;
                     r_inhibit <= HYST_ON;
                  end else begin
                     r_state <= ST_HOLDOFF;
                     r_use   <= 1'b0;
                     r_hcnt  <= bus.holdoff - 1'b1;
                  end
               end
               ST_HOLDOFF: begin
                  if (r_hcnt != '0) begin
                     r_hcnt <= r_hcnt - 1'b1;
                  end else begin
                     r_state   <= ST_ARMED;
                     r_inhibit <= HYST_ON;
                  end
               end
               default: begin
                  r_state <= ST_ARMED;
                  r_use   <= 1'b0;
               end
            endcase
         end
      end
   end

   logic [DELAY-1:0]         r_dly_vld;
   logic [DELAY-1:0][BW-1:0] r_dly_i, r_dly_q;

   always_ff @(posedge adcClk) begin
      if (!adcReset_n) begin
         r_dly_vld <= '0;
         r_dly_i   <= '0;
         r_dly_q   <= '0;
      end else begin
         r_dly_vld <= {r_dly_vld[DELAY-2:0], bus.adcValidIn};
         r_dly_i   <= {r_dly_i[DELAY-2:0], bus.adcIIn};
         r_dly_q   <= {r_dly_q[DELAY-2:0], bus.adcQIn};
      end
   end

   assign bus.adcValidOut         = r_dly_vld[DELAY-1];
   assign bus.adcIOut             = r_dly_i[DELAY-1];
   assign bus.adcQOut             = r_dly_q[DELAY-1];
   assign bus.adcChannelsAbove    = r_above;
   assign bus.adcExceedsThreshold = r_exceeds;
   assign bus.adcUseThisSample    = r_use;
   assign bus.adcTriggerStrobe    = r_strobe;
   assign bus.adcTriggerCount     = r_trig_cnt;

endmodule
